// File: rtl/colour_pkg.sv
// Shared colour definitions for the RGB <-> 3-bit colour code converters.
`timescale 1ns/1ps
package colour_pkg;

    localparam int unsigned CHAN_W   = 8;
    localparam int unsigned RGB_W    = 3 * CHAN_W;
    localparam int unsigned COLOUR_W = 3;

    // Bit positions of each channel inside a colour code
    localparam int unsigned RED   = 2;
    localparam int unsigned GREEN = 1;
    localparam int unsigned BLUE  = 0;

    // Channel slice ranges inside a 24-bit {R,G,B} pixel
    localparam int unsigned R_HI = 23;
    localparam int unsigned R_LO = 16;
    localparam int unsigned G_HI = 15;
    localparam int unsigned G_LO = 8;
    localparam int unsigned B_HI = 7;
    localparam int unsigned B_LO = 0;

    typedef logic [COLOUR_W-1:0] colour_t;
    typedef logic [CHAN_W-1:0]   chan_t;
    typedef logic [RGB_W-1:0]    rgb_t;

    localparam colour_t COL_BLACK   = 3'b000;
    localparam colour_t COL_BLUE    = 3'b001;
    localparam colour_t COL_GREEN   = 3'b010;
    localparam colour_t COL_CYAN    = 3'b011;
    localparam colour_t COL_RED     = 3'b100;
    localparam colour_t COL_MAGENTA = 3'b101;
    localparam colour_t COL_YELLOW  = 3'b110;
    localparam colour_t COL_WHITE   = 3'b111;

    localparam chan_t CHAN_ZERO = 8'h00;
    localparam chan_t CHAN_FULL = 8'hFF;

endpackage

// File: rtl/rgb_channel_quant.sv
// Quantises one 8-bit colour channel to a single bit and flags pure 00/FF values.
`timescale 1ns/1ps
module rgb_channel_quant
    import colour_pkg::*;
#(
    parameter chan_t THRESH = 8'h80
) (
    input  logic [CHAN_W-1:0] chan,
    output logic              q_c,
    output logic              pure_c
);

    // Unsigned threshold compare; a zero threshold maps every value to 1
    always_comb begin
        q_c    = (chan >= THRESH);
        pure_c = (chan == CHAN_ZERO) || (chan == CHAN_FULL);
    end

endmodule

// File: rtl/rgb_colour_encoder.sv
// 24-bit RGB pixel to 3-bit colour code, 2-stage valid/ready pipeline with
// a saturating count of emitted pixels that were not pure 00/FF per channel.
`timescale 1ns/1ps
module rgb_colour_encoder
    import colour_pkg::*;
#(
    parameter chan_t       THRESH = 8'h80,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [RGB_W-1:0]    in_rgb,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [COLOUR_W-1:0] out_colour,
    output logic                out_exact,
    output logic [CNT_W-1:0]    inexact_cnt
);

    logic                s1_valid_q, s1_valid_d;
    logic [RGB_W-1:0]    s1_rgb_q,   s1_rgb_d;
    logic                out_valid_q,  out_valid_d;
    logic [COLOUR_W-1:0] out_colour_q, out_colour_d;
    logic                out_exact_q,  out_exact_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;

    logic s2_adv_c, s1_adv_c, accept_c, xfer_c;
    logic q_r_c, q_g_c, q_b_c;
    logic pure_r_c, pure_g_c, pure_b_c;
    logic [COLOUR_W-1:0] colour_c;

    // Per-channel quantisers on the stage-1 pixel
    rgb_channel_quant #(.THRESH(THRESH)) u_quant_r (
        .chan   (s1_rgb_q[R_HI:R_LO]),
        .q_c    (q_r_c),
        .pure_c (pure_r_c)
    );

    rgb_channel_quant #(.THRESH(THRESH)) u_quant_g (
        .chan   (s1_rgb_q[G_HI:G_LO]),
        .q_c    (q_g_c),
        .pure_c (pure_g_c)
    );

    rgb_channel_quant #(.THRESH(THRESH)) u_quant_b (
        .chan   (s1_rgb_q[B_HI:B_LO]),
        .q_c    (q_b_c),
        .pure_c (pure_b_c)
    );

    // Assemble the colour code from the channel bits
    always_comb begin
        colour_c        = '0;
        colour_c[RED]   = q_r_c;
        colour_c[GREEN] = q_g_c;
        colour_c[BLUE]  = q_b_c;
    end

    // Handshake control: each stage advances when it is empty or its consumer advances
    always_comb begin
        s2_adv_c = enable && (!out_valid_q || out_ready);
        s1_adv_c = enable && (!s1_valid_q || s2_adv_c);
        accept_c = in_valid && s1_adv_c;
        xfer_c   = out_valid_q && out_ready && enable;
    end

    // Next-state for both pipeline stages and the inexact counter
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_rgb_d     = s1_rgb_q;
        out_valid_d  = out_valid_q;
        out_colour_d = out_colour_q;
        out_exact_d  = out_exact_q;
        cnt_d        = cnt_q;

        if (s1_adv_c) begin
            s1_valid_d = accept_c;
            if (accept_c) begin
                s1_rgb_d = in_rgb;
            end
        end

        if (s2_adv_c) begin
            if (s1_valid_q) begin
                out_valid_d  = 1'b1;
                out_colour_d = colour_c;
                out_exact_d  = pure_r_c && pure_g_c && pure_b_c;
            end else begin
                out_valid_d  = 1'b0;
            end
        end

        // Saturate rather than wrap
        if (xfer_c && !out_exact_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset; in-flight pixels are discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_rgb_q     <= '0;
            out_valid_q  <= 1'b0;
            out_colour_q <= '0;
            out_exact_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_rgb_q     <= s1_rgb_d;
            out_valid_q  <= out_valid_d;
            out_colour_q <= out_colour_d;
            out_exact_q  <= out_exact_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready    = s1_adv_c;
    assign out_valid   = out_valid_q;
    assign out_colour  = out_colour_q;
    assign out_exact   = out_exact_q;
    assign inexact_cnt = cnt_q;

endmodule

// File: tb/tb_rgb_colour_encoder.sv
// Directed bench for rgb_colour_encoder: hand-computed expected colours are
// queued per test and compared on every output transfer.
`timescale 1ns/1ps
module tb_rgb_colour_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_rgb;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_colour;
    logic        out_exact;
    logic [7:0]  inexact_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Expected {exact, colour} per emitted pixel, in order
    logic [3:0] exp_q[$];

    rgb_colour_encoder #(.THRESH(8'h80), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rgb      (in_rgb),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_colour  (out_colour),
        .out_exact   (out_exact),
        .inexact_cnt (inexact_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Score any transfer happening at the coming edge, then advance one cycle
    task automatic tick();
        logic [3:0] e;
        if (out_valid && out_ready && enable) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {28'd0, out_exact, out_colour}, 32'hDEAD);
            end else begin
                e = exp_q.pop_front();
                chk("out_exact_colour", {28'd0, out_exact, out_colour}, {28'd0, e});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (exp_q.size() != 0 || out_valid); i++) tick();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    logic [23:0] pix [8];

    initial begin
        pix[0] = 24'h000000; pix[1] = 24'h0000FF; pix[2] = 24'h00FF00; pix[3] = 24'h00FFFF;
        pix[4] = 24'hFF0000; pix[5] = 24'hFF00FF; pix[6] = 24'hFFFF00; pix[7] = 24'hFFFFFF;

        rst = 1'b1; enable = 1'b1; in_valid = 1'b0; in_rgb = '0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_colour", out_colour, 0);
        chk("rst_out_exact", out_exact, 0);
        chk("rst_cnt", inexact_cnt, 0);
        chk("rst_in_ready", in_ready, 1);

        // Test 1: pure colours stream in order with latency 2
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 3'(i)});
        in_valid = 1'b1; in_rgb = pix[0];
        tick();
        chk("t1_lat_edge1", out_valid, 0);
        in_rgb = pix[1];
        tick();
        chk("t1_lat_edge2", out_valid, 1);
        for (int i = 2; i < 8; i++) begin
            in_rgb = pix[i];
            tick();
        end
        in_valid = 1'b0;
        drain();
        chk("t1_cnt", inexact_cnt, 0);

        // Test 2: threshold boundary 7F/80/81
        exp_q.push_back({1'b0, 3'b011});
        in_valid = 1'b1; in_rgb = 24'h7F8081;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t2_cnt_before", inexact_cnt, 0);
        tick();
        chk("t2_cnt_after", inexact_cnt, 1);

        // Test 3: backpressure accepts two, then stalls
        exp_q.push_back({1'b1, 3'b100});
        exp_q.push_back({1'b1, 3'b010});
        exp_q.push_back({1'b1, 3'b001});
        out_ready = 1'b0;
        in_valid = 1'b1; in_rgb = 24'hFF0000;
        #1 chk("t3_ready_a", in_ready, 1);
        tick();
        in_rgb = 24'h00FF00;
        #1 chk("t3_ready_b", in_ready, 1);
        tick();
        in_rgb = 24'h0000FF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_stall_ready", in_ready, 0);
            chk("t3_stall_valid", out_valid, 1);
            chk("t3_stall_colour", out_colour, 3'b100);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        drain();

        // Test 4: enable low freezes everything
        exp_q.push_back({1'b0, 3'b111});
        exp_q.push_back({1'b1, 3'b011});
        exp_q.push_back({1'b1, 3'b110});
        in_valid = 1'b1; in_rgb = 24'h808080;
        tick();
        in_rgb = 24'h00FFFF;
        tick();
        enable = 1'b0; in_rgb = 24'hFFFF00;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_frz_ready", in_ready, 0);
            chk("t4_frz_valid", out_valid, 1);
            chk("t4_frz_colour", out_colour, 3'b111);
            chk("t4_frz_cnt", inexact_cnt, 1);
            tick();
        end
        enable = 1'b1;
        tick();
        in_valid = 1'b0;
        drain();
        chk("t4_cnt", inexact_cnt, 2);

        // Test 5: counter saturates (2 + 300 would wrap to 46)
        for (int i = 0; i < 300; i++) exp_q.push_back({1'b0, 3'b000});
        in_valid = 1'b1; in_rgb = 24'h404040;
        for (int i = 0; i < 300; i++) tick();
        in_valid = 1'b0;
        drain();
        chk("t5_cnt_sat", inexact_cnt, 8'hFF);

        // Test 6: reset with both stages full and enable low
        out_ready = 1'b0;
        in_valid = 1'b1; in_rgb = 24'hFFFFFF;
        tick();
        in_rgb = 24'h000000;
        tick();
        in_valid = 1'b0;
        chk("t6_full_valid", out_valid, 1);
        enable = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_cnt", inexact_cnt, 0);
        chk("t6_rst_ready", in_ready, 0);
        exp_q.push_back({1'b1, 3'b101});
        enable = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_rgb = 24'hFF00FF;
        #1 chk("t6_ready_en", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("t6_lat_edge1", out_valid, 0);
        tick();
        chk("t6_lat_edge2", out_valid, 1);
        drain();
        chk("t6_cnt_final", inexact_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
